// File: rtl/mem_refill_arbiter_if.sv
// Bundle between the two cache requesters, the refill arbiter and the
// shared word-wide backing memory.
interface mem_refill_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
);
    localparam int BW = DATA_WIDTH << BLOCK_SIZE;

    logic                     i_req;
    logic [ADDRESS_WIDTH-1:0] i_addr;
    logic [BW-1:0]            i_block;
    logic                     i_done;

    logic                     d_req;
    logic                     d_we;
    logic [ADDRESS_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0]    d_wdata;
    logic [BW-1:0]            d_block;
    logic                     d_done;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_ready;
    logic                     mem_rvalid;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    logic                     busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output i_block, i_done, d_block, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  i_block, i_done, d_block, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sequencing I/D block refills and D write-through
// stores onto one handshaked word-wide memory port.
module mem_refill_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_refill_arbiter_if.slave bus
);
    localparam int HW = ADDRESS_WIDTH - BLOCK_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [BLOCK_SIZE-1:0] k;
    logic [HW-1:0]         base_hi;
    logic                  sel_d;
    logic                  prio_d;
    logic                  grant_d;
    logic [HW-1:0]         grant_hi;

    always_comb begin
        grant_d  = bus.d_req && (!bus.i_req || prio_d);
        grant_hi = grant_d ? bus.d_addr[ADDRESS_WIDTH-1:BLOCK_SIZE]
                           : bus.i_addr[ADDRESS_WIDTH-1:BLOCK_SIZE];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            base_hi       <= '0;
            sel_d         <= 1'b0;
            prio_d        <= 1'b1;
            bus.i_block   <= '0;
            bus.d_block   <= '0;
            bus.i_done    <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        // Favour the loser of this grant next time both ask.
                        prio_d      <= !grant_d;
                        sel_d       <= grant_d;
                        base_hi     <= grant_hi;
                        k           <= '0;
                        bus.busy    <= 1'b1;
                        bus.mem_req <= 1'b1;
                        if (grant_d && bus.d_we) begin
                            state         <= WRITE;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                        end else begin
                            state        <= ISSUE;
                            bus.mem_addr <= {grant_hi, {BLOCK_SIZE{1'b0}}};
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        state       <= WAIT;
                        bus.mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (sel_d) begin
                            bus.d_block[k*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
                        end else begin
                            bus.i_block[k*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
                        end
                        if (k == '1) begin
                            state      <= DONE;
                            bus.i_done <= !sel_d;
                            bus.d_done <= sel_d;
                        end else begin
                            k            <= k + 1'b1;
                            state        <= ISSUE;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {base_hi, k + 1'b1};
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        state         <= DONE;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wdata <= '0;
                        bus.d_done    <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus.i_done <= 1'b0;
                    bus.d_done <= 1'b0;
                    bus.busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed plus randomized bench for mem_refill_arbiter with a
// transaction-level memory/requester model.
module tb_mem_refill_arbiter;
    localparam int DW = 32;
    localparam int AW = 30;
    localparam int BS = 3;
    localparam int NW = 1 << BS;
    localparam int BW = DW * NW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_refill_arbiter_if #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)
    ) bus ();

    mem_refill_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_plan = 0;
    int i_cnt = 0;
    int d_cnt = 0;
    bit stray_en = 1'b0;
    bit fav_d = 1'b1;
    int st[NW];
    int lt[NW];
    logic [BW-1:0] m_iblk = '0;
    logic [BW-1:0] m_dblk = '0;

    acc_t exp_q[$];
    rsp_t resp_q[$];
    int   stall_q[$];
    int   lat_q[$];

    task automatic chk(input string tag, input logic [BW-1:0] o,
                       input logic [BW-1:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Memory acceptance side: count and check every accepted request.
    initial begin
        acc_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && bus.mem_req === 1'b1 && bus.mem_ready === 1'b1) begin
                n_acc++;
                chk("acc_n", n_acc <= n_plan, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("acc_we", bus.mem_we, e.we);
                    chk("acc_addr", bus.mem_addr, e.addr);
                    chk("acc_wdata", bus.mem_wdata, e.wdata);
                end
                if (!bus.mem_we) begin
                    resp_q.push_back('{due: cyc + cur_lat,
                                       data: 32'h100 + DW'(bus.mem_addr)});
                end
            end
        end
    end

    int  cur_lat = 1;
    int  stall_left = 0;
    bit  active = 1'b0;
    bit  prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [DW-1:0] prev_wdata;

    // Memory response side plus per-cycle output monitors.
    initial begin
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.i_done === 1'b1) i_cnt++;
            if (bus.d_done === 1'b1) d_cnt++;
            if (!rst && prev_stall) begin
                chk("stall_req", bus.mem_req, 1'b1);
                chk("stall_addr", bus.mem_addr, prev_addr);
                chk("stall_we", bus.mem_we, prev_we);
                chk("stall_wdata", bus.mem_wdata, prev_wdata);
            end
            if (bus.mem_we !== 1'b1) chk("wdata_zero", bus.mem_wdata, '0);
            if (bus.mem_req === 1'b1 && !active) begin
                active     = 1'b1;
                stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                cur_lat    = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            end
            if (bus.mem_req !== 1'b1) active = 1'b0;
            if (bus.mem_req === 1'b1) begin
                bus.mem_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                if (bus.mem_ready) active = 1'b0;
            end else begin
                bus.mem_ready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            prev_stall = (bus.mem_req === 1'b1) && !bus.mem_ready;
            prev_addr  = bus.mem_addr;
            prev_we    = bus.mem_we;
            prev_wdata = bus.mem_wdata;
            if (resp_q.size() > 0 && resp_q[0].due == cyc + 1) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = resp_q[0].data;
                void'(resp_q.pop_front());
            end else if (stray_en && resp_q.size() == 0
                         && (bus.mem_req === 1'b1 || bus.busy === 1'b0)
                         && $urandom_range(0, 1) == 1) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = $urandom;
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end
        end
    end

    task automatic fill(input bit rnd);
        for (int w = 0; w < NW; w++) begin
            st[w] = rnd ? int'($urandom_range(0, 2)) : 0;
            lt[w] = rnd ? int'($urandom_range(1, 3)) : 1;
        end
    endtask

    // Expected accepts, memory timing and resulting block for one grant.
    task automatic plan(input bit sd, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output int lat);
        logic [BW-1:0] blk;
        logic [AW-1:0] wa;
        lat   = 1;
        blk   = '0;
        fav_d = !sd;
        if (sd && we) begin
            exp_q.push_back('{we: 1'b1, addr: a, wdata: wd});
            stall_q.push_back(st[0]);
            lat_q.push_back(lt[0]);
            n_plan++;
            lat += st[0] + 1;
        end else begin
            for (int w = 0; w < NW; w++) begin
                wa = {a[AW-1:BS], BS'(w)};
                exp_q.push_back('{we: 1'b0, addr: wa, wdata: '0});
                stall_q.push_back(st[w]);
                lat_q.push_back(lt[w]);
                n_plan++;
                lat += st[w] + 1 + lt[w];
                blk[w*DW +: DW] = 32'h100 + DW'(wa);
            end
            if (sd) m_dblk = blk;
            else    m_iblk = blk;
        end
    endtask

    task automatic wait_done(input bit sd, input int exp_cyc,
                             input string tag);
        int  n = 0;
        bit  got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if ((sd ? bus.d_done : bus.i_done) === 1'b1) got = 1'b1;
        end
        chk({tag, "_seen"}, got, 1'b1);
        chk({tag, "_cyc"}, cyc, exp_cyc);
        chk({tag, "_other"}, sd ? bus.i_done : bus.d_done, 1'b0);
    endtask

    task automatic txn(input bit sd, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input string tag);
        int lat;
        int c0;
        int ic;
        int dc;
        plan(sd, we, a, wd, lat);
        ic = i_cnt;
        dc = d_cnt;
        if (sd) begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = a;
            bus.d_wdata = wd;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = a;
        end
        c0 = cyc;
        wait_done(sd, c0 + lat, tag);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_pulse"}, {bus.i_done, bus.d_done}, 2'b00);
        chk({tag, "_icnt"}, i_cnt, ic + (sd ? 0 : 1));
        chk({tag, "_dcnt"}, d_cnt, dc + (sd ? 1 : 0));
        chk({tag, "_iblk"}, bus.i_block, m_iblk);
        chk({tag, "_dblk"}, bus.d_block, m_dblk);
        chk({tag, "_nacc"}, n_acc, n_plan);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_mreq"}, bus.mem_req, 1'b0);
        chk({tag, "_mwe"}, bus.mem_we, 1'b0);
        chk({tag, "_maddr"}, bus.mem_addr, '0);
        chk({tag, "_mwdata"}, bus.mem_wdata, '0);
        chk({tag, "_done"}, {bus.i_done, bus.d_done}, 2'b00);
        chk({tag, "_iblk"}, bus.i_block, '0);
        chk({tag, "_dblk"}, bus.d_block, '0);
    endtask

    initial begin
        int lat;
        int c0;
        int i0;
        int d0;
        int a0;
        int n;
        bit gs;
        bit dwe;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;

        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;

        fill(0);
        txn(1'b0, 1'b0, 30'h13, '0, "t1");
        chk("t1_w0", bus.i_block[DW-1:0], 32'h110);
        chk("t1_w7", bus.i_block[BW-1 -: DW], 32'h117);

        fill(0);
        txn(1'b1, 1'b1, 30'h25, 32'hDEADBEEF, "t2");

        fill(0);
        st[2] = 3;
        lt[2] = 5;
        txn(1'b0, 1'b0, 30'h48, '0, "t4");

        stray_en = 1'b1;
        fill(0);
        for (int w = 0; w < NW; w++) st[w] = 2;
        txn(1'b1, 1'b0, 30'h3F0, '0, "t6");
        repeat (6) @(negedge clk);
        chk("t6_iblk", bus.i_block, m_iblk);
        chk("t6_dblk", bus.d_block, m_dblk);

        for (int r = 0; r < 24; r++) begin
            gs  = 1'($urandom_range(0, 1));
            dwe = 1'($urandom_range(0, 1));
            fill(1);
            txn(gs, gs & dwe, AW'($urandom), $urandom, "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        stray_en = 1'b0;
        fill(0);
        lt[5] = 3;
        a0 = n_acc;
        i0 = i_cnt;
        d0 = d_cnt;
        plan(1'b1, 1'b0, 30'h2A8, '0, lat);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 30'h2A8;
        n = 0;
        while (n_acc < a0 + 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach", n_acc, a0 + 6);
        rst = 1'b1;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk_zero("t5_rst");
        rst = 1'b0;
        m_iblk = '0;
        m_dblk = '0;
        fav_d  = 1'b1;
        n = 0;
        while (resp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_late", resp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("t5_dcnt", d_cnt, d0);
        chk("t5_icnt", i_cnt, i0);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_dblk", bus.d_block, '0);
        chk("t5_left", exp_q.size(), 2);
        exp_q.delete();
        stall_q.delete();
        lat_q.delete();
        n_plan = n_acc;
        fill(0);
        txn(1'b0, 1'b0, 30'h1234, '0, "t5_after");

        rst = 1'b1;
        @(negedge clk);
        chk_zero("t3_rst");
        rst = 1'b0;
        m_iblk = '0;
        m_dblk = '0;
        fav_d  = 1'b1;
        i0 = i_cnt;
        d0 = d_cnt;
        for (int r = 0; r < 6; r++) begin
            gs  = fav_d;
            ia  = AW'($urandom);
            da  = AW'($urandom);
            dwe = 1'($urandom_range(0, 1));
            dwd = $urandom;
            fill(1);
            bus.i_req   = 1'b1;
            bus.i_addr  = ia;
            bus.d_req   = 1'b1;
            bus.d_we    = dwe;
            bus.d_addr  = da;
            bus.d_wdata = dwd;
            if (gs) plan(1'b1, dwe, da, dwd, lat);
            else    plan(1'b0, 1'b0, ia, '0, lat);
            c0 = (r == 0) ? cyc : cyc + 1;
            wait_done(gs, c0 + lat, gs ? "t3_d" : "t3_i");
            chk("t3_iblk", bus.i_block, m_iblk);
            chk("t3_dblk", bus.d_block, m_dblk);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("t3_busy", bus.busy, 1'b0);
        chk("t3_icnt", i_cnt, i0 + 3);
        chk("t3_dcnt", d_cnt, d0 + 3);
        repeat (4) @(negedge clk);
        chk("end_nacc", n_acc, n_plan);
        chk("end_expq", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Sequences block refills and write-through stores between the instruction cache and the data cache, and one shared, handshaked word-wide backing memory.
- Grants one requester at a time using round-robin arbitration.
- For a refill, reads the 2**BLOCK_SIZE words of the block one at a time, assembles them into a block-wide register and pulses done to the requester.
- For a data store, issues a single-word write.

Parameters:
- DATA_WIDTH, 32, bits per memory word.
- ADDRESS_WIDTH, 30, word-address width; byte offset is already stripped.
- BLOCK_SIZE, 3, log2 of words per cache block.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-cache refill request; held high until i_done.
- i_addr  in  ADDRESS_WIDTH  refill word address; low BLOCK_SIZE bits ignored.
- i_block  out  DATA_WIDTH*2**BLOCK_SIZE  assembled instruction block.
- i_done  out  1  one-cycle pulse when i_block is complete.
- d_req  in  1  data-side request; held high until d_done.
- d_we  in  1  1 = single-word write-through, 0 = block refill.
- d_addr  in  ADDRESS_WIDTH  word address; full address for writes, block-aligned for refills.
- d_wdata  in  DATA_WIDTH  store data.
- d_block  out  DATA_WIDTH*2**BLOCK_SIZE  assembled data block.
- d_done  out  1  one-cycle pulse when a data transaction completes.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write strobe; qualified by mem_req.
- mem_addr  out  ADDRESS_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ready  in  1  request accepted in any cycle where mem_req && mem_ready.
- mem_rvalid  in  1  read data valid; minimum 1 cycle after accept, in order.
- mem_rdata  in  DATA_WIDTH  read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; word counter k=0; round-robin priority favours D; all outputs 0, including i_block and d_block.
- Reset mid-transaction aborts with no done pulse. Any late mem_rvalid after the abort is ignored.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - Requests are sampled only here.
  - Grant: if only one request is high, grant it. If both are high, grant the side not granted last; the priority bit updates on every grant.
  - Latch the granted address and wdata, set k=0, and go to WRITE (if D and d_we=1) or ISSUE (otherwise).
- ISSUE:
  - Drive mem_req=1, mem_we=0, mem_addr={base[ADDRESS_WIDTH-1:BLOCK_SIZE], k}.
  - On mem_ready go to WAIT; otherwise hold all outputs stable.
  - mem_rvalid is ignored in this state.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, write mem_rdata into the granted block at bits [k*DATA_WIDTH +: DATA_WIDTH].
  - If k == 2**BLOCK_SIZE-1 go to DONE; else k=k+1 and go to ISSUE. k wraps only through reset/IDLE.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata.
  - On mem_ready go to DONE. No rvalid is expected for writes.
  - d_block is not modified.
- DONE:
  - Assert i_done or d_done for exactly one cycle, then go to IDLE.
  - Block registers hold their value until the next fill to the same side. Partial contents during a fill are not valid.
- Requester protocol:
  - A requester drops req on the edge where it samples done=1, so IDLE sees the updated req.
  - If req drops mid-transaction, the transaction still completes and done still pulses.
  - Request inputs are not sampled outside IDLE.
- mem_wdata is 0 and mem_we is 0 whenever not in WRITE.
- Latency (mem_ready=1, rvalid one cycle after accept; cycle 0 = IDLE with req high):
  - Refill: mem_req first high in cycle 1; done in cycle 2*2**BLOCK_SIZE+1, which is cycle 17 for BLOCK_SIZE=3.
  - Write: mem_req in cycle 1, done in cycle 2.
- Both requests high in the DONE cycle: the other side is granted in the following IDLE cycle, so there is no starvation.

Test Plan:
1. Reset, then i_req=1 with i_addr=0x0000_0013, memory returns rdata=0x100+addr -> mem_addr steps 0x10..0x17 in order; i_done pulses once in cycle 17; i_block word k=0x110+k; d_done stays 0.
2. d_req=1, d_we=1, d_addr=0x25, d_wdata=0xDEADBEEF, mem_ready=1 -> mem_req/mem_we high one cycle with mem_addr=0x25 and mem_wdata=0xDEADBEEF; d_done in cycle 2; d_block unchanged.
3. i_req and d_req both high from reset -> D granted first; after d_done, I granted next IDLE; repeating both requests alternates I/D with no starvation.
4. mem_ready low for 3 cycles in ISSUE for word 2, and rvalid delayed 4 cycles -> mem_addr and mem_req stable while stalled; no extra request issued; block contents correct; done delayed by exactly 7 cycles.
5. rst asserted in WAIT during word 5 of a D refill, stray mem_rvalid the next cycle -> no d_done; busy=0 and all outputs 0 after reset edge; next I refill completes normally.
6. mem_rvalid pulsed while in ISSUE and in IDLE -> ignored; block contents unaffected.
